pif_led_seq: RTL and testbench
==============================

# pif_led_seq

Registered LED sequencer that sits between the `pifctl` control register and the red/green LED output buffers. It takes the 4-bit LED mode from `MiscReg` and produces glitch-free, clock-synchronous red/green drive. It replaces the combinational mode mux and adds a PWM "breathe" mode. All timing is derived from `xclk` through an internal prescaler and phase counter.

## Interface

Parameters:

- `PRESCALE`, 1000: `xclk` cycles per tick; legal range ≥ 2.
- `HALF_TICKS`, 500: ticks per half flash period; legal range ≥ 1.
- `PWM_BITS`, 4: PWM counter and duty width; legal range 2..8.

Ports:

- `xclk` in 1: the single clock; all state is in this domain.
- `sys_rst` in 1: reset, asynchronous and active-low; asserting it clears all state immediately.
- `mode` in 4: LED mode, driven from `MiscReg`, already synchronous to `xclk`.
  - Values come from `pifdefs.v`: `LED_OFF`, `LED_ALTERNATING`, `LED_SYNC`, and `LED_BREATHE`.
  - `LED_BREATHE` is a new define added to `pifdefs.v` alongside this block.
- `red` out 1: red LED drive, registered.
- `green` out 1: green LED drive, registered.
- `phase` out 1: current flash phase, registered; exported for bench observation.

## Operation

State:

- `mode_q[3:0]`: mode register.
- `pre_cnt`: `$clog2(PRESCALE)` bits.
- `ph_cnt`: `$clog2(HALF_TICKS)` bits, minimum 1 bit.
- `phase`: flash phase bit.
- `duty[PWM_BITS-1:0]`: breathe duty.
- `dir`: breathe direction; 0 = up, 1 = down.
- `pwm_cnt[PWM_BITS-1:0]`: PWM counter.

Reset value, for every register and every output: 0, with `mode_q` = `LED_OFF`.

Mode change (`mode != mode_q`, the restart condition):

- `mode_q` loads `mode`.
- `pre_cnt`, `ph_cnt`, `phase`, `duty`, `dir` and `pwm_cnt` clear.
- `red` and `green` are forced to 0 on that edge.
- The restart takes priority over every other update in the same cycle.

Prescaler:

- `tick` is combinational: `pre_cnt == PRESCALE-1`.
- `pre_cnt` wraps to 0 on tick, otherwise increments.

Phase counter:

- Advances only on tick.
- On tick with `ph_cnt == HALF_TICKS-1` (`wrap`): `ph_cnt` goes to 0 and `phase` toggles.

Breathe duty (updates on `wrap` only, in every mode, but only used in breathe):

- When `dir` = 0: `duty` increments. When `duty` reaches `2**PWM_BITS-1`, `dir` goes to 1 in the same update.
- When `dir` = 1: `duty` decrements. When `duty` reaches 0, `dir` goes to 0.
- `duty` never wraps.

PWM counter: `pwm_cnt` increments every cycle, modulo `2**PWM_BITS`.

Outputs, registered from current state each cycle:

- `LED_ALTERNATING`: `red` = `phase`, `green` = ~`phase`.
- `LED_SYNC`: `red` = `green` = `phase`.
- `LED_BREATHE`: `red` = `green` = (`pwm_cnt < duty`), an unsigned compare. Duty 0 gives always off; the maximum gives (2^N−1)/2^N on-time.
- `LED_OFF` and all undefined codes: both outputs 0. Counters keep running.
- `phase` output equals the internal `phase` register.

## Timing

- Mode change sequence:
  - Cycle T: `mode` differs from `mode_q`.
  - Edge T+1: restart takes effect; `red`/`green` = 0.
  - Edge T+2: outputs reflect the new mode at phase 0. For `LED_ALTERNATING` this is `red`=0, `green`=1.
- First `phase` toggle: at edge T+1+`PRESCALE`·`HALF_TICKS`. `red`/`green` follow one edge later.
- Steady state:
  - `phase` has period 2·`PRESCALE`·`HALF_TICKS` cycles, 50% duty.
  - `duty` steps once per half period.
  - A full breathe cycle is 2·(2^`PWM_BITS`−1) half periods.
- Mode held constant: no restart ever occurs; a rewrite of the same value is a no-op.
- Mode changing on consecutive cycles: each change restarts again. Outputs stay 0 until one cycle after `mode` is stable.
- Reset mid-operation: outputs drop to 0 asynchronously. After `sys_rst` is released, the first rising edge resumes counting from 0 with `mode_q` = `LED_OFF`. If `mode` ≠ `LED_OFF` at that point, a restart follows.

## Test plan

All scenarios use `PRESCALE`=4, `HALF_TICKS`=3, `PWM_BITS`=4.

1. Reset:
   - Stimulus: hold `sys_rst`=0 with `mode`=`LED_SYNC`, then release.
   - Required: `red`=`green`=`phase`=0 during reset; 0 on the first edge after release (restart); `phase` first toggles 12 cycles after the restart edge.
2. Alternating:
   - Stimulus: `mode`=`LED_ALTERNATING`.
   - Required: after restart, `red`=0, `green`=1 for 12 cycles, then `red`=1, `green`=0 for 12 cycles, repeating with period 24. `red` and `green` are never equal after the restart cycle.
3. Sync to off:
   - Stimulus: in `LED_SYNC` mid-phase with outputs at 1, switch to `LED_OFF`.
   - Required: both outputs are 0 on the next edge and stay 0. Switching back to `LED_SYNC` restarts with `phase`=0.
4. Breathe ramp:
   - Stimulus: `mode`=`LED_BREATHE`.
   - Required: `duty` is 0,1,2,…,15,14,…,0,1 at successive 12-cycle half periods, with no wrap past 15 or 0. With `duty`=5, outputs are high for exactly 5 of every 16 cycles.
5. Illegal mode:
   - Stimulus: `mode`=4'hF.
   - Required: outputs 0 while `phase` keeps toggling every 12 cycles.
6. Async reset mid-run:
   - Stimulus: assert `sys_rst` in `LED_ALTERNATING` mid-phase, between clock edges.
   - Required: `green` drops to 0 without waiting for a clock edge. After release, the sequence from scenario 1 repeats.

Source files
------------

// File: rtl/pif_led_seq.sv
// LED mode codes plus the registered red/green LED sequencer. It provides alternating
// and sync flash modes and a PWM breathe mode, all timed from xclk.
package pif_led_pkg;
   localparam logic [3:0] LED_OFF         = 4'h0;
   localparam logic [3:0] LED_ALTERNATING = 4'h1;
   localparam logic [3:0] LED_SYNC        = 4'h2;
   localparam logic [3:0] LED_BREATHE     = 4'h3;
endpackage

module pif_led_seq
   import pif_led_pkg::*;
#(
   parameter int PRESCALE   = 1000,
   parameter int HALF_TICKS = 500,
   parameter int PWM_BITS   = 4
) (
   input  logic       xclk,
   input  logic       sys_rst,
   input  logic [3:0] mode,
   output logic       red,
   output logic       green,
   output logic       phase
);
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int PH_W  = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(HALF_TICKS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ZERO = '0;

   logic [3:0]          mode_q;
   logic [PRE_W-1:0]    pre_cnt;
   logic [PH_W-1:0]     ph_cnt;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] duty_d;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                dir;
   logic                dir_d;
   logic                restart;
   logic                tick;
   logic                wrap;
   logic                red_d;
   logic                green_d;

   assign restart = (mode != mode_q);
   assign tick    = (pre_cnt == PRE_LAST);
   assign wrap    = tick && (ph_cnt == PH_LAST);

   // Triangle ramp: direction flips in the same update that reaches an end stop.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch inferred.
      duty_d = duty;
      dir_d  = dir;
      if (wrap) begin
         if (!dir) begin
            duty_d = duty + PWM_BITS'(1);
            if (duty_d == DUTY_MAX) dir_d = 1'b1;
         end else begin
            duty_d = duty - PWM_BITS'(1);
            if (duty_d == DUTY_ZERO) dir_d = 1'b0;
         end
      end
   end

   always_comb begin
      red_d   = 1'b0;
      green_d = 1'b0;
      case (mode_q)
         LED_ALTERNATING: begin
            red_d   = phase;
            green_d = ~phase;
         end
         LED_SYNC: begin
            red_d   = phase;
            green_d = phase;
         end
         LED_BREATHE: begin
            red_d   = (pwm_cnt < duty);
            green_d = (pwm_cnt < duty);
         end
         default: ;
      endcase
   end

   // A mode change restarts every timer and blanks the LEDs for one edge.
   always_ff @(posedge xclk or negedge sys_rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!sys_rst) begin
         mode_q  <= LED_OFF;
         pre_cnt <= '0;
         ph_cnt  <= '0;
         phase   <= 1'b0;
         duty    <= '0;
         dir     <= 1'b0;
         pwm_cnt <= '0;
         red     <= 1'b0;
         green   <= 1'b0;
      end else if (restart) begin
         mode_q  <= mode;
         pre_cnt <= '0;
         ph_cnt  <= '0;
         phase   <= 1'b0;
         duty    <= '0;
         dir     <= 1'b0;
         pwm_cnt <= '0;
         red     <= 1'b0;
         green   <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         if (tick) ph_cnt <= wrap ? '0 : ph_cnt + PH_W'(1);
         if (wrap) phase <= ~phase;
         duty    <= duty_d;
         dir     <= dir_d;
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         red     <= red_d;
         green   <= green_d;
      end
   end

endmodule

// File: tb/tb_pif_led_seq.sv
// Bench for pif_led_seq: directed scenarios plus random mode sequences, checked
// against a closed-form model indexed by edges since the last all-zero state.
module tb_pif_led_seq;
   import pif_led_pkg::*;

   localparam int PRESCALE   = 4;
   localparam int HALF_TICKS = 3;
   localparam int PWM_BITS   = 4;
   localparam int HALF_P     = PRESCALE * HALF_TICKS;
   localparam int DMAX       = (1 << PWM_BITS) - 1;
   localparam int PWM_PERIOD = 1 << PWM_BITS;

   logic       xclk;
   logic       sys_rst;
   logic [3:0] mode;
   logic       red;
   logic       green;
   logic       phase;

   int         checks;
   int         errors;

   // Model state: edges since counters were last zero, and the latched mode.
   int         n;
   logic [3:0] mq;
   logic       r_exp;
   logic       g_exp;

   pif_led_seq #(
      .PRESCALE  (PRESCALE),
      .HALF_TICKS(HALF_TICKS),
      .PWM_BITS  (PWM_BITS)
   ) dut (
      .xclk   (xclk),
      .sys_rst(sys_rst),
      .mode   (mode),
      .red    (red),
      .green  (green),
      .phase  (phase)
   );

   initial xclk = 1'b0;
   always #5 xclk = ~xclk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   function automatic logic ph_of(input int k);
      return ((k / HALF_P) % 2) == 1;
   endfunction

   function automatic int duty_of(input int k);
      int m;
      m = (k / HALF_P) % (2 * DMAX);
      return (m <= DMAX) ? m : 2 * DMAX - m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at time %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      n     = 0;
      mq    = LED_OFF;
      r_exp = 1'b0;
      g_exp = 1'b0;
   endtask

   // Drive mode, take one edge, advance the model, then compare all outputs.
   task automatic step(input logic [3:0] m);
      logic ph;
      logic on;
      mode = m;
      @(posedge xclk);
      if (!sys_rst) begin
         model_reset();
      end else if (m != mq) begin
         mq    = m;
         n     = 0;
         r_exp = 1'b0;
         g_exp = 1'b0;
      end else begin
         ph = ph_of(n);
         on = (n % PWM_PERIOD) < duty_of(n);
         r_exp = 1'b0;
         g_exp = 1'b0;
         if (mq == LED_ALTERNATING) begin
            r_exp = ph;
            g_exp = ~ph;
         end else if (mq == LED_SYNC) begin
            r_exp = ph;
            g_exp = ph;
         end else if (mq == LED_BREATHE) begin
            r_exp = on;
            g_exp = on;
         end
         n++;
      end
      #1;
      check("red", red, r_exp);
      check("green", green, g_exp);
      check("phase", phase, ph_of(n));
   endtask

   initial begin
      int toggle_at;
      checks  = 0;
      errors  = 0;
      model_reset();
      sys_rst = 1'b0;
      mode    = LED_SYNC;

      // Reset held with a non-OFF mode waiting.
      #1;
      check("rst_red", red, 1'b0);
      check("rst_green", green, 1'b0);
      check("rst_phase", phase, 1'b0);
      repeat (3) step(LED_SYNC);
      sys_rst = 1'b1;
      step(LED_SYNC);
      check("restart_red", red, 1'b0);
      toggle_at = -1;
      for (int k = 1; k <= 20; k++) begin
         step(LED_SYNC);
         if (toggle_at < 0 && phase === 1'b1) toggle_at = k;
      end
      check("first_toggle_sync", toggle_at, 12);

      // Sync with outputs high, then off, then back to sync.
      check("sync_high", red & green, 1'b1);
      step(LED_OFF);
      check("off_red", red, 1'b0);
      check("off_green", green, 1'b0);
      repeat (30) step(LED_OFF);
      step(LED_SYNC);
      check("resync_phase", phase, 1'b0);
      repeat (10) step(LED_SYNC);

      // Alternating: complementary outputs after the restart edge.
      step(LED_ALTERNATING);
      step(LED_ALTERNATING);
      check("alt_first_red", red, 1'b0);
      check("alt_first_green", green, 1'b1);
      for (int k = 0; k < 50; k++) begin
         step(LED_ALTERNATING);
         check("alt_neq", red ^ green, 1'b1);
      end

      // Breathe through a complete ramp and beyond.
      step(LED_BREATHE);
      repeat (2 * DMAX * HALF_P + 40) step(LED_BREATHE);

      // Undefined code: dark LEDs, phase still running.
      step(4'hF);
      repeat (40) step(4'hF);

      // Asynchronous reset between edges while green is lit.
      step(LED_ALTERNATING);
      repeat (5) step(LED_ALTERNATING);
      check("pre_rst_green", green, 1'b1);
      #3;
      sys_rst = 1'b0;
      model_reset();
      #1;
      check("async_green", green, 1'b0);
      check("async_red", red, 1'b0);
      check("async_phase", phase, 1'b0);
      repeat (2) step(LED_ALTERNATING);
      sys_rst = 1'b1;
      step(LED_ALTERNATING);
      check("rst2_restart_green", green, 1'b0);
      toggle_at = -1;
      for (int k = 1; k <= 20; k++) begin
         step(LED_ALTERNATING);
         if (toggle_at < 0 && phase === 1'b1) toggle_at = k;
      end
      check("first_toggle_alt", toggle_at, 12);

      // Random mode sequences, including back-to-back changes.
      for (int s = 0; s < 40; s++) begin
         logic [3:0] m;
         int len;
         case ($urandom_range(0, 4))
            0:       m = LED_OFF;
            1:       m = LED_ALTERNATING;
            2:       m = LED_SYNC;
            3:       m = LED_BREATHE;
            default: m = 4'($urandom_range(4, 15));
         endcase
         len = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 60));
         repeat (len) step(m);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
